// File: rtl/ex_muldiv_seq_if.sv
// ex_muldiv_seq_if
// Handshake and operand bundle between the EX stage and the iterative
// RV32M multiply/divide sequencer.
//   start   EX holds a valid M-op (level, held until done)
//   funct3  M-op selector (MUL..REMU)
//   srcA    rs1 value after forwarding
//   srcB    rs2 value after forwarding
//   flush   EX instruction squashed; aborts any operation
//   stall   freeze IF/ID/EX (combinational in the sequencer)
//   done    one-cycle pulse, result valid
//   result  registered 32-bit result
// master: EX stage side. slave: sequencer side.
interface ex_muldiv_seq_if;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, funct3, srcA, srcB, flush,
        input  stall, done, result
    );

    modport slave (
        input  start, funct3, srcA, srcB, flush,
        output stall, done, result
    );
endinterface

// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq
// Iterative RV32M multiply/divide unit for the EX stage. Multiplies by
// shift-add and divides by restoring division, one bit per cycle, on
// operand magnitudes; signs are applied in a final fix-up cycle.
// Ports:
//   CLK  core clock, rising edge
//   RST  synchronous active-high reset
//   bus  ex_muldiv_seq_if.slave (start/funct3/srcA/srcB/flush in,
//        stall/done/result out)
//
// state | meaning
// IDLE  | waiting for start; special divide cases finish from here
// BUSY  | 32 shift-add / restoring-divide iterations
// FIX   | apply signs, select output half, write result
// DONE  | done pulse; back to IDLE
module ex_muldiv_seq (
    input  logic            CLK,
    input  logic            RST,
    ex_muldiv_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [2:0]  r_f3;
    logic [31:0] r_bmag;
    logic [31:0] r_hi;       // product high half / partial remainder
    logic [31:0] r_lo;       // multiplier shifting out / quotient shifting in
    logic        r_neg_q;    // negate product or quotient
    logic        r_neg_r;    // negate remainder
    logic [31:0] r_result;
    logic        r_done;

    logic        w_is_div;
    logic        w_a_signed;
    logic        w_b_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic        w_div0;
    logic        w_ovf;
    logic        w_special;
    logic [31:0] w_special_res;
    logic [32:0] w_mul_sum;
    logic [32:0] w_div_sh;
    logic [32:0] w_div_diff;
    logic [63:0] w_prod;
    logic [63:0] w_prod_s;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_fix_res;

    // Operand sign handling at accept time. MULHSU treats only srcA as signed;
    // MULHU and the U divides treat both as unsigned.
    assign w_is_div   = bus.funct3[2];
    assign w_a_signed = w_is_div ? ~bus.funct3[0] : (bus.funct3 != 3'b011);
    assign w_b_signed = w_is_div ? ~bus.funct3[0] : ~bus.funct3[1];
    assign w_a_neg    = w_a_signed & bus.srcA[31];
    assign w_b_neg    = w_b_signed & bus.srcB[31];
    assign w_a_mag    = w_a_neg ? (32'd0 - bus.srcA) : bus.srcA;
    assign w_b_mag    = w_b_neg ? (32'd0 - bus.srcB) : bus.srcB;

    assign w_div0     = w_is_div & (bus.srcB == 32'd0);
    assign w_ovf      = w_is_div & ~bus.funct3[0] &
                        (bus.srcA == 32'h8000_0000) & (bus.srcB == 32'hFFFF_FFFF);
    assign w_special  = w_div0 | w_ovf;
    // funct3[1] separates REM/REMU from DIV/DIVU among the divides.
    assign w_special_res = w_div0 ? (bus.funct3[1] ? bus.srcA : 32'hFFFF_FFFF)
                                  : (bus.funct3[1] ? 32'd0    : 32'h8000_0000);

    // Shift-add step: add multiplicand into the high half when the current
    // multiplier bit is set, then shift the 65-bit {carry,hi,lo} right by one.
    assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_bmag} : 33'd0);

    // Restoring step: the shifted remainder is always < 2*divisor, so bit 32
    // of the difference is a reliable borrow flag.
    assign w_div_sh   = {r_hi, r_lo[31]};
    assign w_div_diff = w_div_sh - {1'b0, r_bmag};

    assign w_prod     = {r_hi, r_lo};
    assign w_prod_s   = r_neg_q ? (64'd0 - w_prod) : w_prod;
    assign w_quo      = r_neg_q ? (32'd0 - r_lo) : r_lo;
    assign w_rem      = r_neg_r ? (32'd0 - r_hi) : r_hi;

    always_comb begin
        w_fix_res = 32'd0;
        case (r_f3)
            3'b000:                  w_fix_res = w_prod_s[31:0];
            3'b001, 3'b010, 3'b011:  w_fix_res = w_prod_s[63:32];
            3'b100, 3'b101:          w_fix_res = w_quo;
            default:                 w_fix_res = w_rem;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_cnt    <= 5'd0;
            r_f3     <= 3'd0;
            r_bmag   <= 32'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= 32'd0;
            r_done   <= 1'b0;
        end else if (bus.flush) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_f3    <= bus.funct3;
                        r_bmag  <= w_b_mag;
                        r_hi    <= 32'd0;
                        r_lo    <= w_a_mag;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_cnt   <= 5'd0;
                        if (w_special) begin
                            r_result <= w_special_res;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_state  <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (r_f3[2]) begin
                        if (!w_div_diff[32]) begin
                            r_hi <= w_div_diff[31:0];
                            r_lo <= {r_lo[30:0], 1'b1};
                        end else begin
                            r_hi <= w_div_sh[31:0];
                            r_lo <= {r_lo[30:0], 1'b0};
                        end
                    end else begin
                        r_hi <= w_mul_sum[32:1];
                        r_lo <= {w_mul_sum[0], r_lo[31:1]};
                    end
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_result <= w_fix_res;
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.stall  = ~RST & (((r_state == S_IDLE) & bus.start & ~bus.flush) |
                                (r_state == S_BUSY) | (r_state == S_FIX));
    assign bus.done   = r_done;
    assign bus.result = r_result;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// tb_ex_muldiv_seq
// Self-checking bench for ex_muldiv_seq: directed cases, abort/reset
// scenarios, back-to-back timing and randomized ops against an arithmetic
// reference model.
module tb_ex_muldiv_seq;

    logic clk = 1'b0;
    logic rst;

    ex_muldiv_seq_if bus ();

    ex_muldiv_seq dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int n_done   = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.done) n_done <= n_done + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the RV32M definitions.
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub, p;
        logic [63:0] pu;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'h0, b});
        r  = 32'd0;
        case (f3)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin pu = {32'h0, a} * {32'h0, b}; r = pu[63:32]; end
            3'd4: begin
                if (b == 32'd0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: r = (b == 32'd0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && (b == 32'd0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return 34;
    endfunction

    // Called just after a rising edge. Holds start until done, measures
    // latency and stall cycles, returns just after the DONE->IDLE edge with
    // start still high.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat, input logic [31:0] exp_res, input string tag,
                         output int done_cyc);
        int   lat;
        int   stl;
        bit   seen;
        logic stall_at_done;
        bus.start  = 1'b1;
        bus.flush  = 1'b0;
        bus.funct3 = f3;
        bus.srcA   = a;
        bus.srcB   = b;
        lat = -1; stl = 0; seen = 1'b0; done_cyc = -1; stall_at_done = 1'bx;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = k; seen = 1'b1; done_cyc = cyc; stall_at_done = bus.stall;
                break;
            end
            if (bus.stall) stl++;
            @(posedge clk); #1;
        end
        check_val({tag, " done_seen"}, {31'd0, seen}, 32'd1);
        check_val({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check_val({tag, " result"}, bus.result, exp_res);
        check_val({tag, " stall_cycles"}, 32'(stl), 32'(exp_lat));
        check_val({tag, " stall_in_done"}, {31'd0, stall_at_done}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_one(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input logic [31:0] exp_res, input string tag);
        int dc;
        do_op(f3, a, b, exp_lat, exp_res, tag, dc);
        bus.start = 1'b0;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int          dc1, dc2, n_before;
        logic [31:0] last_res;
        logic [31:0] a, b, ma, mb;
        logic [2:0]  f3;

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.funct3 = 3'd0;
        bus.srcA   = 32'd0;
        bus.srcB   = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b1;
        @(negedge clk);
        check_val("reset done", {31'd0, bus.done}, 32'd0);
        check_val("reset stall_with_start", {31'd0, bus.stall}, 32'd0);
        check_val("reset result", bus.result, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check_val("idle stall", {31'd0, bus.stall}, 32'd0);
        @(posedge clk); #1;

        // Directed
        do_one(3'd0, 32'd7, 32'hFFFF_FFFD, 34, 32'hFFFF_FFEB, "MUL 7*-3");
        @(negedge clk);
        check_val("MUL hold result", bus.result, 32'hFFFF_FFEB);
        check_val("MUL hold done", {31'd0, bus.done}, 32'd0);
        @(posedge clk); #1;
        do_one(3'd1, 32'h8000_0000, 32'h8000_0000, 34, 32'h4000_0000, "MULH");
        do_one(3'd2, 32'h8000_0000, 32'h8000_0000, 34, 32'hC000_0000, "MULHSU");
        do_one(3'd3, 32'h8000_0000, 32'h8000_0000, 34, 32'h4000_0000, "MULHU");
        do_one(3'd5, 32'd100, 32'd7, 34, 32'd14, "DIVU 100/7");
        do_one(3'd7, 32'd100, 32'd7, 34, 32'd2, "REMU 100/7");
        do_one(3'd4, 32'hFFFF_FF9C, 32'd7, 34, 32'hFFFF_FFF2, "DIV -100/7");
        do_one(3'd6, 32'hFFFF_FF9C, 32'd7, 34, 32'hFFFF_FFFE, "REM -100/7");
        do_one(3'd4, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, "DIV 5/0");
        do_one(3'd7, 32'd5, 32'd0, 1, 32'd5, "REMU 5/0");
        do_one(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, "DIV ovf");
        do_one(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, "REM ovf");
        last_res = 32'd0;

        // Abort by flush in the middle of a divide
        n_before   = n_done;
        bus.start  = 1'b1;
        bus.funct3 = 3'd5;
        bus.srcA   = 32'd1000;
        bus.srcB   = 32'd3;
        repeat (10) begin @(posedge clk); #1; end
        bus.flush = 1'b1;
        @(negedge clk);
        check_val("abort stall_busy", {31'd0, bus.stall}, 32'd1);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check_val("abort no_done", 32'(n_done), 32'(n_before));
        check_val("abort result_kept", bus.result, last_res);
        do_one(3'd0, 32'd12345, 32'd678, 34, 32'd8369910, "MUL after abort");

        // flush with start in IDLE is not accepted
        bus.start  = 1'b1;
        bus.flush  = 1'b1;
        bus.funct3 = 3'd0;
        @(negedge clk);
        check_val("flush+start stall", {31'd0, bus.stall}, 32'd0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        n_before  = n_done;
        @(negedge clk);
        check_val("flush+start not_busy", {31'd0, bus.stall}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_val("flush+start no_done", 32'(n_done), 32'(n_before));

        // Reset in the middle of an op
        bus.start  = 1'b1;
        bus.funct3 = 3'd0;
        bus.srcA   = 32'd99;
        bus.srcB   = 32'd77;
        repeat (20) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_val("midrst result", bus.result, 32'd0);
        check_val("midrst done", {31'd0, bus.done}, 32'd0);
        check_val("midrst stall", {31'd0, bus.stall}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check_val("midrst idle", {31'd0, bus.stall}, 32'd0);
        @(posedge clk); #1;

        // Back-to-back MUL then DIV
        do_op(3'd0, 32'd6, 32'd9, 34, 32'd54, "b2b MUL", dc1);
        do_op(3'd4, 32'd54, 32'hFFFF_FFFA, 34, 32'hFFFF_FFF7, "b2b DIV", dc2);
        bus.start = 1'b0;
        check_val("b2b spacing", 32'(dc2 - dc1), 32'd35);

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            ma = ref_model(f3, a, b);
            do_op(f3, a, b, ref_latency(f3, a, b), ma, $sformatf("rnd%0d f%0d", i, f3), dc1);
            if ($urandom_range(0, 3) == 0) begin
                bus.start = 1'b0;
                @(posedge clk); #1;
            end
        end
        bus.start = 1'b0;
        mb = 32'd0;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_seq.md
# ex_muldiv_seq

Iterative RV32M multiply/divide sequencer for the EX stage of the pipelined OTTER core. When a decoded M-extension instruction reaches EX, it takes the already-forwarded rs1/rs2 operands and stalls the pipeline. It computes the result with a shift-add (multiply) or restoring (divide) loop, one bit per cycle. It then presents the 32-bit result for one cycle, in parallel with the ALU result, for the EX/MEM result mux.

## Interface
No parameters: width fixed at 32.
- CLK  in  1  core clock, all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- start  in  1  EX holds a valid M-op; level, held by the stalled pipeline until done
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- srcA  in  32  rs1 value (post-forwarding)
- srcB  in  32  rs2 value (post-forwarding)
- flush  in  1  EX instruction squashed (branch/jump redirect); aborts any operation
- stall  out  1  freeze IF/ID/EX; combinational
- done  out  1  one-cycle pulse, result valid
- result  out  32  registered result, held until next accepted start

## Operation
- States: IDLE, BUSY, FIX, DONE.
- IDLE:
  - start=1 and flush=0 → accept: latch funct3, operand magnitudes and result-sign flags; counter=0.
  - Special cases go directly to DONE with result loaded:
    - divide by zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → srcA.
    - signed overflow (DIV/REM with srcA=0x80000000, srcB=0xFFFFFFFF): DIV → 0x80000000; REM → 0.
  - Otherwise → BUSY.
- BUSY: 32 iterations, counter 0..31.
  - Multiply: 64-bit unsigned product of magnitudes, one shift-add per cycle.
  - Divide: restoring, one quotient bit per cycle, 32-bit remainder.
  - After iteration 31 → FIX.
- FIX: apply sign and select output half, write result, → DONE.
  - MUL: low 32 bits of the signed product.
  - MULH: high 32 bits; both operands signed.
  - MULHSU: high 32 bits; srcA signed, srcB unsigned.
  - MULHU: high 32 bits; both unsigned.
  - DIV quotient: negated when operand signs differ.
  - REM remainder: takes the dividend's sign.
  - U variants: no sign handling.
- DONE: done=1, → IDLE unconditionally. start is not re-sampled in DONE: the same instruction leaves EX that cycle.
- stall = (state==IDLE & start & ~flush) | state==BUSY | state==FIX. stall is 0 in DONE.
- flush=1 in any state → IDLE next edge; done is not raised; result keeps its old value.
- RST (any state) → IDLE, counter 0, internal regs 0, result=0, done=0. stall is 0 while RST is high.

## Timing
- Start accepted at edge N:
  - normal op: FIX during cycle N+33, done=1 during cycle N+34; latency 34 cycles.
  - special case: done=1 during cycle N+1.
- stall is high from the cycle start is first seen in IDLE through the cycle before done.
- result is updated at the edge that enters DONE and is stable while done=1 and afterward.
- Back-to-back M-ops: second start is accepted in the IDLE cycle after DONE; no gap beyond that.
- flush and start asserted together in IDLE: not accepted, stall=0.
- Reset values: done=0, stall=0 (with start low), result=0x00000000.

## Test plan
- MUL srcA=7, srcB=0xFFFFFFFD (-3) → done at N+34, result=0xFFFFFFEB; stall high for exactly 34 cycles.
- MULH / MULHSU / MULHU with srcA=srcB=0x80000000:
  - MULH → 0x40000000
  - MULHSU → 0xC0000000
  - MULHU → 0x40000000
- DIVU 100/7 → 14; REMU 100/7 → 2; DIV -100/7 → 0xFFFFFFF2 (-14); REM -100/7 → 0xFFFFFFFE (-2).
- Special cases, each with done at N+1:
  - DIV 5/0 → 0xFFFFFFFF
  - REMU 5/0 → 5
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000
  - REM of the same → 0
- Abort: start DIVU, flush at cycle N+10 → IDLE at N+11, no done pulse, result unchanged. A new MUL start at N+11 completes normally.
- Reset mid-op: RST at N+20 → next cycle state IDLE, result=0, done=0. Back-to-back MUL then DIV yields two done pulses 35 cycles apart.
